mem_write_checker: RTL

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

---
 rtl/mem_write_checker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_write_checker.sv
// Checks that a monitored bus performs NUM_EXP expected writes in order; writes to IGN_ADDR are tolerated.
// Status is registered, one cycle after the deciding write. Pure monitor, no backpressure.
// Optional RUN-cycle timeout is enabled by defining MEM_WRITE_CHECKER_TIMEOUT_EN.
module mem_write_checker #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_EXP     = 1,
    parameter logic [ADDR_W-1:0] IGN_ADDR    = 80,
    parameter int                TIMEOUT_CYC = 1000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clr,
    input  logic                           memwrite,
    input  logic [ADDR_W-1:0]              dataadr,
    input  logic [DATA_W-1:0]              writedata,
    input  logic [NUM_EXP*ADDR_W-1:0]      exp_addr,
    input  logic [NUM_EXP*DATA_W-1:0]      exp_data,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic [1:0]                     fail_code,
    output logic [$clog2(NUM_EXP+1)-1:0]   match_cnt,
    output logic [15:0]                    ign_cnt,
    output logic [ADDR_W-1:0]              err_addr,
    output logic [DATA_W-1:0]              err_data
);
    localparam int MCW = $clog2(NUM_EXP+1);
    localparam logic [MCW-1:0] NUM_EXP_C = MCW'(NUM_EXP);

    // Encoding chosen so pass/fail come straight off state flops.
    typedef enum logic [1:0] {
        RUN  = 2'b00,
        PASS = 2'b01,
        FAIL = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [MCW-1:0]     match_d;
    logic [15:0]        ign_d;
    logic [1:0]         fc_d;
    logic [ADDR_W-1:0]  ea_d, cur_addr;
    logic [DATA_W-1:0]  ed_d, cur_data;
    logic               hit;

`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    localparam int RCW = $clog2(TIMEOUT_CYC+1);
    localparam logic [RCW-1:0] TO_C = RCW'(TIMEOUT_CYC);
    logic [RCW-1:0] run_q, run_d;
`endif

    assign pass = state_q[0];
    assign fail = state_q[1];
    assign done = state_q[0] | state_q[1];

    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            if (match_cnt == MCW'(i)) begin
                cur_addr = exp_addr[i*ADDR_W +: ADDR_W];
                cur_data = exp_data[i*DATA_W +: DATA_W];
            end
        end
        hit = (dataadr == cur_addr) && (writedata == cur_data);
    end

    always_comb begin
        state_d = state_q;
        match_d = match_cnt;
        ign_d   = ign_cnt;
        fc_d    = fail_code;
        ea_d    = err_addr;
        ed_d    = err_data;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
        run_d   = run_q;
`endif
        if (clr) begin
            state_d = RUN;
            match_d = '0;
            ign_d   = '0;
            fc_d    = 2'b00;
            ea_d    = '0;
            ed_d    = '0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
            run_d   = '0;
`endif
        end else if (state_q == RUN) begin
            if (memwrite) begin
                // Expected entry is checked before the ignore address.
                if (hit) begin
                    match_d = match_cnt + 1'b1;
                    if (match_d == NUM_EXP_C)
                        state_d = PASS;
                end else if (dataadr == IGN_ADDR) begin
                    if (ign_cnt != 16'hFFFF)
                        ign_d = ign_cnt + 16'd1;
                end else begin
                    state_d = FAIL;
                    fc_d    = 2'b01;
                    ea_d    = dataadr;
                    ed_d    = writedata;
                end
            end
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
            run_d = run_q + 1'b1;
            // A deciding write on the terminal edge beats the timeout.
            if (state_d == RUN && run_d == TO_C) begin
                state_d = FAIL;
                fc_d    = 2'b10;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            match_cnt <= '0;
            ign_cnt   <= '0;
            fail_code <= 2'b00;
            err_addr  <= '0;
            err_data  <= '0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
            run_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            match_cnt <= match_d;
            ign_cnt   <= ign_d;
            fail_code <= fc_d;
            err_addr  <= ea_d;
            err_data  <= ed_d;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
            run_q     <= run_d;
`endif
        end
    end
endmodule
